serial_divisibility_scheduler: RTL and testbench



---
 rtl/serial_divisibility_scheduler_if.sv | 29 ++
 rtl/serial_divisibility_scheduler.sv | 128 ++++++++++++
 tb/tb_serial_divisibility_scheduler.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_divisibility_scheduler_if.sv
// Requester-side and result-side handshakes of serial_divisibility_scheduler.
// The scheduler uses the slave modport; producers and the result consumer use master.
interface serial_divisibility_scheduler_if #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 5
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int REM_W = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [ID_W-1:0]        res_id;
    logic [REM_W-1:0]       res_rem;
    logic                   res_div;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_rem, res_div
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_rem, res_div
    );
endinterface

// File: rtl/serial_divisibility_scheduler.sv
// Round-robin front end that shares one bit-serial mod-DIVISOR remainder engine
// between N_REQ requesters and returns remainder, divisibility flag and requester id.
module serial_divisibility_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 5
) (
    input logic                            clk,
    input logic                            rst,
    serial_divisibility_scheduler_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int REM_W = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [REM_W:0] DIV_C = (REM_W + 1)'(DIVISOR);

    typedef enum logic [1:0] {IDLE, SHIFT, RESULT} state_t;

    // 2*rem + b stays below 2*DIVISOR, so one conditional subtract is exact.
    function automatic logic [REM_W-1:0] rem_step(input logic [REM_W-1:0] rem, input logic b);
        logic [REM_W:0] t;
        t = {rem, b};
        if (t >= DIV_C) begin
            t = t - DIV_C;
        end
        return t[REM_W-1:0];
    endfunction

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  shift_q, shift_d;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]  gnt_word;
    logic              accept;

    // Search above the last grant first, then wrap to the indices at or below it.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && bus.req_valid[i] && (ID_W'(i) > last_grant_q)) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && bus.req_valid[i] && (ID_W'(i) <= last_grant_q)) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(i);
            end
        end
        gnt_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                gnt_word = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept        = (state_q == IDLE) && !rst && gnt_found;
    assign bus.req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        shift_d      = shift_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d      = gnt_word;
                    rem_d        = '0;
                    cnt_d        = CNT_W'(WIDTH);
                    id_d         = gnt_idx;
                    last_grant_d = gnt_idx;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                rem_d   = rem_step(rem_q, shift_q[WIDTH-1]);
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            rem_q        <= '0;
            cnt_q        <= '0;
            id_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
        end
    end

    // The shift register holds only data; it is always loaded before use.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign bus.res_valid = (state_q == RESULT);
    assign bus.res_id    = id_q;
    assign bus.res_rem   = rem_q;
    assign bus.res_div   = (state_q == RESULT) && (rem_q == '0);
endmodule

// File: tb/tb_serial_divisibility_scheduler.sv
// Bench for serial_divisibility_scheduler: directed scenarios plus a randomized run
// checked against a round-robin / modulo reference model.
module tb_serial_divisibility_scheduler;
    localparam int N_REQ   = 4;
    localparam int WIDTH   = 8;
    localparam int DIVISOR = 5;
    localparam int LAT     = WIDTH + 1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_ref = N_REQ - 1;

    serial_divisibility_scheduler_if #(.N_REQ(4), .WIDTH(8), .DIVISOR(5)) bus ();
    serial_divisibility_scheduler_if #(.N_REQ(2), .WIDTH(4), .DIVISOR(3)) bus2 ();

    serial_divisibility_scheduler #(.N_REQ(4), .WIDTH(8), .DIVISOR(5)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    serial_divisibility_scheduler #(.N_REQ(2), .WIDTH(4), .DIVISOR(3)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    always #5 clk = ~clk;

    // Round-robin reference: first valid index after 'last', wrapping; -1 if none.
    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            int i;
            i = (last + k) % N_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] word_of(input int i);
        return bus.req_data[i*WIDTH +: WIDTH];
    endfunction

    task automatic accept_word(output int gid, output logic [N_REQ-1:0] rdy, output bit timeout);
        gid = -1; rdy = '0; timeout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (|(bus.req_valid & bus.req_ready)) begin
                rdy = bus.req_ready;
                for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) gid = i;
                @(posedge clk); #1;
                bus.req_valid[gid] = 1'b0;
                timeout = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_result(output int lat, output bit timeout);
        lat = 0; timeout = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                lat = k; timeout = 1'b0;
                return;
            end
        end
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        last_ref = N_REQ - 1;
        @(negedge clk);
        n_checks++;
        if (bus.res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
        n_checks++;
        if (bus.res_div !== 1'b0) begin n_errors++; $display("FAIL reset_res_div got=%b exp=0", bus.res_div); end
        n_checks++;
        if (bus.res_rem !== 3'd0) begin n_errors++; $display("FAIL reset_res_rem got=%0d exp=0", bus.res_rem); end
        n_checks++;
        if (bus.res_id !== 2'd0) begin n_errors++; $display("FAIL reset_res_id got=%0d exp=0", bus.res_id); end
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin n_errors++; $display("FAIL reset_first_priority got=%b exp=0001", bus.req_ready); end
        n_checks++;
        if (bus2.res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid2 got=%b exp=0", bus2.res_valid); end
        bus.req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int gid, lat; logic [N_REQ-1:0] rdy; bit to;
        bus.req_data[2*WIDTH +: WIDTH] = 8'h23;
        bus.req_valid = 4'b0100;
        accept_word(gid, rdy, to);
        n_checks++;
        if (to || rdy !== 4'b0100) begin n_errors++; $display("FAIL single_ready got=%b timeout=%0d exp=0100", rdy, to); end
        last_ref = 2;
        wait_result(lat, to);
        n_checks++;
        if (to || lat != LAT) begin n_errors++; $display("FAIL single_latency got=%0d timeout=%0d exp=%0d", lat, to, LAT); end
        n_checks++;
        if (bus.res_id !== 2'd2) begin n_errors++; $display("FAIL single_id got=%0d exp=2", bus.res_id); end
        n_checks++;
        if (bus.res_rem !== 3'd0) begin n_errors++; $display("FAIL single_rem got=%0d exp=0", bus.res_rem); end
        n_checks++;
        if (bus.res_div !== 1'b1) begin n_errors++; $display("FAIL single_div got=%b exp=1", bus.res_div); end
        consume();
    endtask

    task automatic test_values();
        logic [7:0] words[$];
        int gid, lat, er; logic [N_REQ-1:0] rdy; bit to;
        words = '{8'h0D, 8'hFF, 8'h00, 8'h01};
        for (int i = 0; i < 256; i++) words.push_back(8'(i));
        foreach (words[k]) begin
            er = int'(words[k]) % DIVISOR;
            bus.req_data[0 +: WIDTH] = words[k];
            bus.req_valid = 4'b0001;
            accept_word(gid, rdy, to);
            n_checks++;
            if (to || gid != 0) begin n_errors++; $display("FAIL values_grant word=%h got=%0d exp=0", words[k], gid); end
            last_ref = 0;
            wait_result(lat, to);
            n_checks++;
            if (to || lat != LAT) begin n_errors++; $display("FAIL values_latency word=%h got=%0d exp=%0d", words[k], lat, LAT); end
            n_checks++;
            if (bus.res_rem !== 3'(er)) begin n_errors++; $display("FAIL values_rem word=%h got=%0d exp=%0d", words[k], bus.res_rem, er); end
            n_checks++;
            if (bus.res_div !== (er == 0)) begin n_errors++; $display("FAIL values_div word=%h got=%b exp=%0d", words[k], bus.res_div, er == 0); end
            n_checks++;
            if (bus.res_id !== 2'd0) begin n_errors++; $display("FAIL values_id word=%h got=%0d exp=0", words[k], bus.res_id); end
            consume();
        end
    endtask

    task automatic test_fairness();
        int exp_order[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        logic [7:0] dv[N_REQ];
        int ng, cyc, prev, g, lat; bit to;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        last_ref = N_REQ - 1;
        for (int i = 0; i < N_REQ; i++) begin
            dv[i] = 8'($urandom_range(0, 255));
            bus.req_data[i*WIDTH +: WIDTH] = dv[i];
        end
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        ng = 0; cyc = 0; prev = 0;
        while (ng < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.res_valid) begin
                n_checks++;
                if (bus.res_rem !== 3'(int'(dv[bus.res_id]) % DIVISOR)) begin
                    n_errors++; $display("FAIL fair_rem id=%0d got=%0d exp=%0d", bus.res_id, bus.res_rem, int'(dv[bus.res_id]) % DIVISOR);
                end
            end
            if (|(bus.req_valid & bus.req_ready)) begin
                g = -1;
                for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) g = i;
                n_checks++;
                if (g != exp_order[ng]) begin n_errors++; $display("FAIL fair_order n=%0d got=%0d exp=%0d", ng, g, exp_order[ng]); end
                if (ng > 0) begin
                    n_checks++;
                    if (cyc - prev != WIDTH + 2) begin n_errors++; $display("FAIL fair_interval n=%0d got=%0d exp=%0d", ng, cyc - prev, WIDTH + 2); end
                end
                prev = cyc;
                ng++;
            end
            @(posedge clk); #1;
            if (ng == 6) bus.req_valid[1] = 1'b0;
        end
        n_checks++;
        if (ng != 10) begin n_errors++; $display("FAIL fair_grant_count got=%0d exp=10", ng); end
        bus.req_valid = '0;
        last_ref = 2;
        wait_result(lat, to);
        n_checks++;
        if (to || lat != LAT) begin n_errors++; $display("FAIL fair_drain_latency got=%0d exp=%0d", lat, LAT); end
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        int gid, lat, er, nxt; logic [N_REQ-1:0] rdy; bit to;
        bus.res_ready = 1'b0;
        w = 8'($urandom_range(0, 255));
        er = int'(w) % DIVISOR;
        bus.req_data[3*WIDTH +: WIDTH] = w;
        bus.req_valid = 4'b1000;
        accept_word(gid, rdy, to);
        n_checks++;
        if (to || gid != 3) begin n_errors++; $display("FAIL bp_grant got=%0d exp=3", gid); end
        last_ref = 3;
        wait_result(lat, to);
        n_checks++;
        if (to || lat != LAT) begin n_errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) bus.req_data[i*WIDTH +: WIDTH] = 8'($urandom_range(0, 255));
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd3 || bus.res_rem !== 3'(er) || bus.res_div !== (er == 0)) begin
                n_errors++; $display("FAIL bp_hold cyc=%0d got v=%b id=%0d rem=%0d div=%b exp v=1 id=3 rem=%0d div=%0d",
                                     j, bus.res_valid, bus.res_id, bus.res_rem, bus.res_div, er, er == 0);
            end
            n_checks++;
            if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_ready_blocked cyc=%0d got=%b exp=0000", j, bus.req_ready); end
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        nxt = rr_pick(bus.req_valid, last_ref);
        n_checks++;
        if (bus.req_ready !== 4'(1 << nxt)) begin n_errors++; $display("FAIL bp_next_grant got=%b exp=%b", bus.req_ready, 4'(1 << nxt)); end
        er = int'(word_of(nxt)) % DIVISOR;
        @(posedge clk); #1;
        bus.req_valid = '0;
        last_ref = nxt;
        wait_result(lat, to);
        n_checks++;
        if (to || bus.res_id !== 2'(nxt) || bus.res_rem !== 3'(er)) begin
            n_errors++; $display("FAIL bp_next_result got id=%0d rem=%0d exp id=%0d rem=%0d", bus.res_id, bus.res_rem, nxt, er);
        end
        consume();
    endtask

    task automatic test_reset_mid_shift();
        int gid, seen; logic [N_REQ-1:0] rdy; bit to;
        bus.req_data[2*WIDTH +: WIDTH] = 8'($urandom_range(0, 255));
        bus.req_valid = 4'b0100;
        accept_word(gid, rdy, to);
        n_checks++;
        if (to || gid != rr_pick(4'b0100, last_ref)) begin n_errors++; $display("FAIL rst_mid_grant got=%0d exp=2", gid); end
        last_ref = gid;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_mid_ready got=%b exp=0000", bus.req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        last_ref = N_REQ - 1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin n_errors++; $display("FAIL rst_mid_next_grant got=%b exp=0001", bus.req_ready); end
        bus.req_valid = '0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_errors++; $display("FAIL rst_mid_discard res_valid_cycles got=%0d exp=0", seen); end
        @(posedge clk); #1;
    endtask

    task automatic test_param_sweep();
        logic [3:0] ws[$];
        int g, lat, er;
        ws = '{4'hB, 4'h9};
        for (int i = 0; i < 16; i++) ws.push_back(4'(i));
        foreach (ws[k]) begin
            int r;
            r = k % 2;
            er = int'(ws[k]) % 3;
            bus2.req_data[r*4 +: 4] = ws[k];
            bus2.req_valid = 2'(1 << r);
            g = -1;
            for (int c = 0; c < 20 && g < 0; c++) begin
                @(negedge clk);
                if (|(bus2.req_valid & bus2.req_ready)) g = bus2.req_ready[1] ? 1 : 0;
            end
            n_checks++;
            if (g != r) begin n_errors++; $display("FAIL sweep_grant word=%h got=%0d exp=%0d", ws[k], g, r); end
            @(posedge clk); #1;
            bus2.req_valid = '0;
            lat = 0;
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                @(negedge clk);
                if (bus2.res_valid) lat = c;
            end
            n_checks++;
            if (lat != 5) begin n_errors++; $display("FAIL sweep_latency word=%h got=%0d exp=5", ws[k], lat); end
            n_checks++;
            if (bus2.res_rem !== 2'(er) || bus2.res_div !== (er == 0) || bus2.res_id !== 1'(r)) begin
                n_errors++; $display("FAIL sweep_result word=%h got rem=%0d div=%b id=%0d exp rem=%0d div=%0d id=%0d",
                                     ws[k], bus2.res_rem, bus2.res_div, bus2.res_id, er, er == 0, r);
            end
            bus2.res_ready = 1'b1;
            @(posedge clk); #1;
            bus2.res_ready = 1'b0;
        end
    endtask

    task automatic test_random();
        bit outstanding, seen;
        int exp_id, exp_rem, acc_cyc, pend, pk, g;
        logic [N_REQ-1:0] exp_rdy;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        last_ref = N_REQ - 1;
        outstanding = 1'b0; seen = 1'b0; pend = -1;
        exp_id = 0; exp_rem = 0; acc_cyc = 0;
        bus.req_valid = '0;
        for (int c = 0; c < 800; c++) begin
            if (pend >= 0) begin bus.req_valid[pend] = 1'b0; pend = -1; end
            for (int i = 0; i < N_REQ; i++) begin
                if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.req_valid[i] = 1'b1;
                        bus.req_data[i*WIDTH +: WIDTH] = 8'($urandom_range(0, 255));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.res_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            pk = rr_pick(bus.req_valid, last_ref);
            exp_rdy = (outstanding || pk < 0) ? '0 : 4'(1 << pk);
            n_checks++;
            if (bus.req_ready !== exp_rdy) begin n_errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, exp_rdy); end
            if (!bus.res_valid) begin
                n_checks++;
                if (bus.res_div !== 1'b0) begin n_errors++; $display("FAIL rand_div_qualified cyc=%0d got=%b exp=0", c, bus.res_div); end
            end
            if (|(bus.req_valid & bus.req_ready)) begin
                g = -1;
                for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) g = i;
                outstanding = 1'b1; seen = 1'b0;
                exp_id = g; exp_rem = int'(word_of(g)) % DIVISOR; acc_cyc = c;
                last_ref = g; pend = g;
            end
            if (bus.res_valid) begin
                n_checks++;
                if (!outstanding || bus.res_id !== 2'(exp_id) || bus.res_rem !== 3'(exp_rem) || bus.res_div !== (exp_rem == 0)) begin
                    n_errors++; $display("FAIL rand_result cyc=%0d got id=%0d rem=%0d div=%b exp id=%0d rem=%0d pending=%0d",
                                         c, bus.res_id, bus.res_rem, bus.res_div, exp_id, exp_rem, outstanding);
                end
                if (!seen) begin
                    n_checks++;
                    if (c - acc_cyc != LAT) begin n_errors++; $display("FAIL rand_latency cyc=%0d got=%0d exp=%0d", c, c - acc_cyc, LAT); end
                    seen = 1'b1;
                end
                if (bus.res_ready) outstanding = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 30 && outstanding; c++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                n_checks++;
                if (bus.res_id !== 2'(exp_id) || bus.res_rem !== 3'(exp_rem)) begin
                    n_errors++; $display("FAIL rand_drain got id=%0d rem=%0d exp id=%0d rem=%0d", bus.res_id, bus.res_rem, exp_id, exp_rem);
                end
                outstanding = 1'b0;
            end
        end
        n_checks++;
        if (outstanding) begin n_errors++; $display("FAIL rand_drain_timeout got=pending exp=drained"); end
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.res_ready  = 1'b0;
        bus2.req_valid = '0;
        bus2.req_data  = '0;
        bus2.res_ready = 1'b0;
        test_reset();
        test_single();
        test_values();
        test_fairness();
        test_backpressure();
        test_reset_mid_shift();
        test_param_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
